wm_phase_timer: RTL and testbench
=================================

Name: wm_phase_timer

Overview:
- Generates the `timer_soak`, `timer_wash`, `timer_rinse` and `timer_spin` completion signals consumed by the washing-machine control FSM.
- Consumes that FSM's registered `*_en` phase outputs and its `mode1..3`, `lid` and `cancel` inputs.
- Counts a mode-dependent number of prescaled ticks per phase.
- Pauses while the lid is open and aborts on cancel or when the enable drops.

Parameters:
- `TICK_DIV`, default 50_000_000: clk cycles per tick (1 s at 50 MHz); minimum 2.
- `CNT_W`, default 8: width of the remaining-ticks counter.

Ports:
- `clk` in 1: system clock; all logic on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `soak_en`, `wash_en`, `rinse_en`, `spin_en` in 1 each: phase enables from the control FSM.
- `mode1`, `mode2`, `mode3` in 1 each: wash-mode selects.
- `lid` in 1: 0 = closed, 1 = open.
- `cancel` in 1: cancel button.
- `timer_soak`, `timer_wash`, `timer_rinse`, `timer_spin` out 1 each: phase-complete level.
- `remaining` out `CNT_W`: ticks left in the current phase.
- `running` out 1: counter actively decrementing.
- `err` out 1: sticky illegal-enable flag.

Behaviour:
- Reset (sync, `rst` = 1): FSM = T_IDLE; all `timer_*` = 0; `remaining` = 0; `running` = 0; `err` = 0; latched mode = QUICK; prescaler = 0.
- Mode latch: on the rising edge of `soak_en` only. Priority is `mode3` (HEAVY) > `mode2` (NORMAL) > `mode1` (QUICK); none set → QUICK. Mode changes mid-cycle are ignored.
- Durations in ticks (soak/wash/rinse/spin):
  - QUICK = 2/4/2/2
  - NORMAL = 4/8/4/4
  - HEAVY = 8/16/6/6
  - Values are truncated to `CNT_W`.
- Active phase is the single asserted `*_en`. Two or more enables asserted → `err` = 1 (sticky until `rst`), FSM to T_IDLE, all outputs except `err` cleared.
- FSM states: T_IDLE, T_RUN, T_PAUSE, T_DONE.
  - **T_IDLE:** on a rising edge of any single `*_en`, load `remaining` with that phase's duration, clear prescaler, go to T_RUN the next cycle.
  - **T_RUN:**
    - `running` = 1.
    - Prescaler counts 0..`TICK_DIV`-1; a tick occurs on the wrap.
    - On a tick, `remaining` decrements.
    - When `remaining` goes 1→0: go to T_DONE in the same edge; the `timer_*` for that phase rises the following cycle.
    - `lid` = 1 → T_PAUSE. `cancel` = 1 or phase enable low → T_IDLE.
  - **T_PAUSE:**
    - Prescaler and `remaining` hold; `running` = 0.
    - `lid` = 0 and `cancel` = 0 → T_RUN, resuming the prescaler from its held value.
    - `cancel` = 1 or enable low → T_IDLE.
  - **T_DONE:**
    - Matching `timer_*` = 1 as a level, held until its enable drops.
    - Then → T_IDLE with `timer_*` = 0 the next cycle.
    - The level is held because the consumer advances only when `lid` and `cancel` are both 0.
- Priority when events coincide in one cycle: illegal enables > enable drop/cancel > lid > tick.
- T_IDLE → T_IDLE: `remaining` = 0.
- A new enable rising while in T_DONE, with the old enable still high, is illegal → `err`.
- Zero duration (truncation) loads as 1.
- Each `timer_*` is asserted only in T_DONE for its own phase.

Optional Feature:
- Macro `WM_FAST_SIM_EN`.
  - Defined: prescaler bypassed; every clk in T_RUN is a tick.
  - Undefined: normal `TICK_DIV` prescaling.
- The FSM, durations and outputs are otherwise identical.

Decomposition:
- Package `wm_timer_pkg`:
  - FSM state enum (T_IDLE..T_DONE).
  - Mode enum (QUICK, NORMAL, HEAVY).
  - Phase enum (SOAK..SPIN).
  - Duration constant table indexed [mode][phase].
- Sub-module `wm_tick_prescaler`: counter with `en` and `clr` inputs and a `tick` output. Holds when `en` = 0; compiles to pass-through under `WM_FAST_SIM_EN`.

Test Plan:
All scenarios use `TICK_DIV` = 4, `CNT_W` = 8.
1. `mode2` = 1; `soak_en` rises, held. → `remaining` = 4 after load; `timer_soak` rises 1 cycle after the 4th tick, 17 cycles after load; stays 1 until `soak_en` falls, then 0 the next cycle.
2. `mode3` + `mode1` set; full soak→spin sequence, one enable at a time. → HEAVY durations 8/16/6/6 observed on `remaining` at each load.
3. QUICK wash running, `remaining` = 3; `lid` = 1 for 10 cycles. → `running` = 0, `remaining` frozen at 3; after `lid` = 0 the count resumes and `timer_wash` is delayed by exactly 10 cycles.
4. Rinse running, `remaining` = 1, `cancel` = 1 on the tick cycle. → T_IDLE, `remaining` = 0, `timer_rinse` never asserts.
5. `wash_en` and `rinse_en` both asserted. → `err` = 1 next cycle, all `timer_*` = 0; `err` persists until `rst` = 1, then clears.
6. `rst` = 1 mid-T_RUN. → next cycle all outputs 0, T_IDLE; with `WM_FAST_SIM_EN`, NORMAL spin completes 4 cycles after load.

Source files
------------

// File: rtl/wm_timer_pkg.sv
// Purpose : shared types and duration table for the washing-machine phase timer.
// Latency : n/a (types, constants and a mode decoder only).
// Backpressure: n/a.
package wm_timer_pkg;

    typedef enum logic [1:0] {
        T_IDLE  = 2'd0,
        T_RUN   = 2'd1,
        T_PAUSE = 2'd2,
        T_DONE  = 2'd3
    } tstate_e;

    typedef enum logic [1:0] {
        QUICK  = 2'd0,
        NORMAL = 2'd1,
        HEAVY  = 2'd2
    } mode_e;

    typedef enum logic [1:0] {
        SOAK  = 2'd0,
        WASH  = 2'd1,
        RINSE = 2'd2,
        SPIN  = 2'd3
    } phase_e;

    // Phase durations in ticks, indexed [mode][phase] (soak, wash, rinse, spin).
    localparam int unsigned DUR_TBL [3][4] = '{
        '{2,  4, 2, 2},   // QUICK
        '{4,  8, 4, 4},   // NORMAL
        '{8, 16, 6, 6}    // HEAVY
    };

    // Heaviest selected mode wins; nothing selected falls back to QUICK.
    function automatic mode_e mode_decode(input logic m1, input logic m2, input logic m3);
        mode_e m;
        m = QUICK;
        if (m3) begin
            m = HEAVY;
        end else if (m2) begin
            m = NORMAL;
        end else if (m1) begin
            m = QUICK;
        end
        return m;
    endfunction

endpackage

// File: rtl/wm_tick_prescaler.sv
// Purpose : divides clk down to a one-cycle tick every TICK_DIV enabled cycles.
// Latency : tick is combinational on the last count; count updates on the clk edge.
// Backpressure: en = 0 freezes the count; clr restarts it (clr wins over en).
// Ports: clk, rst (sync, active-high), en, clr in; tick out.
// Build option WM_FAST_SIM_EN: tick follows en directly (every enabled cycle is a tick).
module wm_tick_prescaler #(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

`ifdef WM_FAST_SIM_EN
    assign tick = en;
`else
    localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tick = en && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

endmodule

// File: rtl/wm_phase_timer.sv
// Purpose : per-phase completion timer (soak/wash/rinse/spin) for the washer control FSM.
// Latency : remaining loads 1 cycle after an enable rises; timer_* rises 1 cycle after the last tick.
// Backpressure: lid open pauses the count; cancel or enable drop aborts to idle.
// Ports: clk, rst (sync, active-high); soak_en/wash_en/rinse_en/spin_en, mode1..3, lid, cancel in;
//        timer_soak/wash/rinse/spin, remaining[CNT_W], running, err (sticky) out.
// Build option WM_FAST_SIM_EN: prescaler bypassed, every running cycle is a tick.
module wm_phase_timer
    import wm_timer_pkg::*;
#(
    parameter int TICK_DIV = 50_000_000,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             soak_en,
    input  logic             wash_en,
    input  logic             rinse_en,
    input  logic             spin_en,
    input  logic             mode1,
    input  logic             mode2,
    input  logic             mode3,
    input  logic             lid,
    input  logic             cancel,
    output logic             timer_soak,
    output logic             timer_wash,
    output logic             timer_rinse,
    output logic             timer_spin,
    output logic [CNT_W-1:0] remaining,
    output logic             running,
    output logic             err
);

    // Table lookup truncated to the counter width; a zero result becomes 1 so a phase never
    // completes without at least one tick.
    function automatic logic [CNT_W-1:0] dur_of(input mode_e m, input phase_e p);
        logic [CNT_W-1:0] d;
        d = CNT_W'(DUR_TBL[m][p]);
        if (d == '0) begin
            d    = '0;
            d[0] = 1'b1;
        end
        return d;
    endfunction

    tstate_e          state_q, state_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    phase_e           phase_q, phase_d;
    mode_e            mode_q, mode_d;
    logic             err_q, err_d;
    logic [3:0]       timer_q, timer_d;
    logic [3:0]       en_prev_q, en_prev_d;

    logic [3:0] en_vec;
    logic       illegal;
    logic       single_rise;
    phase_e     single_ph;
    logic       cur_en;
    logic       presc_en;
    logic       load;
    logic       tick;

    assign en_vec  = {spin_en, rinse_en, wash_en, soak_en};
    // More than one bit set: clearing the lowest set bit leaves something behind.
    assign illegal = (en_vec & (en_vec - 4'd1)) != 4'd0;
    assign cur_en  = en_vec[phase_q];

    always_comb begin
        single_ph = SOAK;
        case (en_vec)
            4'b0010: single_ph = WASH;
            4'b0100: single_ph = RINSE;
            4'b1000: single_ph = SPIN;
            default: single_ph = SOAK;
        endcase
    end

    // Exactly one enable high and that one just rose.
    assign single_rise = !illegal && ((en_vec & ~en_prev_q) != 4'd0);

    // The prescaler advances whenever the count would be live this cycle, including the
    // cycle that resumes from pause, so a lid opening delays completion by exactly the
    // number of cycles it was open.
    assign presc_en = ((state_q == T_RUN) || (state_q == T_PAUSE)) &&
                      cur_en && !cancel && !lid && !illegal;

    wm_tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .en   (presc_en),
        .clr  (load),
        .tick (tick)
    );

    always_comb begin
        state_d   = state_q;
        rem_d     = rem_q;
        phase_d   = phase_q;
        mode_d    = mode_q;
        err_d     = err_q;
        en_prev_d = en_vec;
        timer_d   = '0;
        load      = 1'b0;

        // Mode is captured only when soak starts; later selector changes are ignored.
        if (soak_en && !en_prev_q[0]) begin
            mode_d = mode_decode(mode1, mode2, mode3);
        end

        if (illegal) begin
            err_d   = 1'b1;
            state_d = T_IDLE;
            rem_d   = '0;
        end else begin
            case (state_q)
                T_IDLE: begin
                    rem_d = '0;
                    if (single_rise) begin
                        load    = 1'b1;
                        phase_d = single_ph;
                        rem_d   = dur_of(mode_d, single_ph);
                        state_d = T_RUN;
                    end
                end
                T_RUN, T_PAUSE: begin
                    if (!cur_en || cancel) begin
                        state_d = T_IDLE;
                        rem_d   = '0;
                    end else if (lid) begin
                        state_d = T_PAUSE;
                    end else begin
                        state_d = T_RUN;
                        if (tick) begin
                            if (rem_q <= CNT_W'(1)) begin
                                rem_d   = '0;
                                state_d = T_DONE;
                            end else begin
                                rem_d = rem_q - 1'b1;
                            end
                        end
                    end
                end
                T_DONE: begin
                    rem_d = '0;
                    if (!cur_en) begin
                        state_d = T_IDLE;
                    end
                end
                default: begin
                    state_d = T_IDLE;
                    rem_d   = '0;
                end
            endcase
        end

        // Completion level is registered: it appears the cycle after entering T_DONE and
        // drops the cycle after the enable falls.
        if ((state_q == T_DONE) && (state_d == T_DONE)) begin
            timer_d[phase_q] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= T_IDLE;
            rem_q     <= '0;
            phase_q   <= SOAK;
            mode_q    <= QUICK;
            err_q     <= 1'b0;
            timer_q   <= '0;
            en_prev_q <= '0;
        end else begin
            state_q   <= state_d;
            rem_q     <= rem_d;
            phase_q   <= phase_d;
            mode_q    <= mode_d;
            err_q     <= err_d;
            timer_q   <= timer_d;
            en_prev_q <= en_prev_d;
        end
    end

    assign timer_soak  = timer_q[0];
    assign timer_wash  = timer_q[1];
    assign timer_rinse = timer_q[2];
    assign timer_spin  = timer_q[3];
    assign remaining   = rem_q;
    assign running     = (state_q == T_RUN);
    assign err         = err_q;

endmodule

// File: tb/tb_wm_phase_timer.sv
// Purpose : directed self-checking bench for wm_phase_timer (TICK_DIV = 4, CNT_W = 8).
// Latency : inputs driven just after a falling edge, outputs sampled at the next falling edge.
// Backpressure: n/a; lid and cancel are driven as directed stimulus.
module tb_wm_phase_timer;

    localparam int TICK_DIV = 4;
    localparam int CNT_W    = 8;
`ifdef WM_FAST_SIM_EN
    localparam int TP = 1;
`else
    localparam int TP = TICK_DIV;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [3:0]       en_v = 4'b0000;
    logic             mode1 = 1'b0;
    logic             mode2 = 1'b0;
    logic             mode3 = 1'b0;
    logic             lid = 1'b0;
    logic             cancel = 1'b0;
    logic             timer_soak, timer_wash, timer_rinse, timer_spin;
    logic [CNT_W-1:0] remaining;
    logic             running;
    logic             err;
    wire  [3:0]       tmr = {timer_spin, timer_rinse, timer_wash, timer_soak};

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    wm_phase_timer #(
        .TICK_DIV (TICK_DIV),
        .CNT_W    (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .soak_en     (en_v[0]),
        .wash_en     (en_v[1]),
        .rinse_en    (en_v[2]),
        .spin_en     (en_v[3]),
        .mode1       (mode1),
        .mode2       (mode2),
        .mode3       (mode3),
        .lid         (lid),
        .cancel      (cancel),
        .timer_soak  (timer_soak),
        .timer_wash  (timer_wash),
        .timer_rinse (timer_rinse),
        .timer_spin  (timer_spin),
        .remaining   (remaining),
        .running     (running),
        .err         (err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Run one phase to completion: load value, completion timing, and release.
    task automatic run_phase(input int ph, input int dur, input string tag);
        logic [3:0] exp_t;
        exp_t     = 4'b0000;
        exp_t[ph] = 1'b1;
        en_v      = exp_t;
        cyc(1);
        chk({tag, "_load"}, remaining, dur);
        cyc(dur * TP);
        chk({tag, "_pre_done"}, tmr, 0);
        cyc(1);
        chk({tag, "_done"}, tmr, exp_t);
        en_v = 4'b0000;
        cyc(1);
        chk({tag, "_release"}, tmr, 0);
        cyc(1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state
        rst = 1'b1;
        cyc(2);
        chk("rst_tmr", tmr, 0);
        chk("rst_rem", remaining, 0);
        chk("rst_run", running, 0);
        chk("rst_err", err, 0);
        rst = 1'b0;
        cyc(1);

        // 1: NORMAL soak, completion 17 cycles after load, level held until enable drops
        mode2 = 1'b1;
        en_v  = 4'b0001;
        cyc(1);
        chk("t1_load", remaining, 4);
        chk("t1_running", running, 1);
        cyc(TP);
        chk("t1_first_tick", remaining, 3);
        cyc(3 * TP - 1);
        chk("t1_rem1", remaining, 1);
        cyc(1);
        chk("t1_rem0", remaining, 0);
        chk("t1_not_yet", tmr, 0);
        cyc(1);
        chk("t1_done", tmr, 4'b0001);
        cyc(3);
        chk("t1_held", tmr, 4'b0001);
        en_v = 4'b0000;
        cyc(1);
        chk("t1_release", tmr, 0);
        mode2 = 1'b0;
        cyc(1);

        // 2: HEAVY via mode3 priority over mode1; selector change after soak is ignored
        mode3 = 1'b1;
        mode1 = 1'b1;
        run_phase(0, 8, "t2_soak");
        mode3 = 1'b0;
        run_phase(1, 16, "t2_wash");
        run_phase(2, 6, "t2_rinse");
        run_phase(3, 6, "t2_spin");
        mode1 = 1'b0;

        // 3: QUICK wash paused by lid for 10 cycles
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        en_v = 4'b0010;
        cyc(1);
        chk("t3_load", remaining, 4);
        cyc(TP);
        chk("t3_rem3", remaining, 3);
        lid = 1'b1;
        cyc(1);
        chk("t3_paused_run", running, 0);
        chk("t3_paused_rem", remaining, 3);
        cyc(9);
        chk("t3_still_paused", running, 0);
        chk("t3_frozen_rem", remaining, 3);
        chk("t3_no_timer", tmr, 0);
        lid = 1'b0;
        cyc(1);
        chk("t3_resumed", running, 1);
        chk("t3_resume_rem", remaining, (TP == 1) ? 2 : 3);
        cyc(3 * TP - 1);
        chk("t3_pre_done", tmr, 0);
        chk("t3_rem0", remaining, 0);
        cyc(1);
        chk("t3_done", tmr, 4'b0010);
        en_v = 4'b0000;
        cyc(2);

        // 4: QUICK rinse cancelled on the final tick
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        en_v = 4'b0100;
        cyc(1);
        chk("t4_load", remaining, 2);
        cyc(2 * TP - 1);
        chk("t4_rem1", remaining, 1);
        cancel = 1'b1;
        cyc(1);
        chk("t4_cancel_rem", remaining, 0);
        chk("t4_cancel_run", running, 0);
        chk("t4_cancel_tmr", tmr, 0);
        cancel = 1'b0;
        cyc(2 * TP + 2);
        chk("t4_idle_rem", remaining, 0);
        chk("t4_never_done", tmr, 0);
        en_v = 4'b0000;
        cyc(1);

        // 5a: new enable rising while soak is done and still enabled is illegal
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        en_v = 4'b0001;
        cyc(1);
        cyc(2 * TP + 1);
        chk("t5_soak_done", tmr, 4'b0001);
        en_v = 4'b0011;
        cyc(1);
        chk("t5_done_err", err, 1);
        chk("t5_done_tmr", tmr, 0);
        en_v = 4'b0000;
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        chk("t5_err_clear", err, 0);

        // 5b: two enables from idle; err sticks until reset
        en_v = 4'b0110;
        cyc(1);
        chk("t5_err", err, 1);
        chk("t5_tmr", tmr, 0);
        chk("t5_rem", remaining, 0);
        chk("t5_run", running, 0);
        en_v = 4'b0000;
        cyc(3);
        chk("t5_sticky", err, 1);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        chk("t5_rst_err", err, 0);
        cyc(1);

        // 6: reset in the middle of a NORMAL spin
        mode2 = 1'b1;
        en_v  = 4'b0001;
        cyc(1);
        chk("t6_soak_load", remaining, 4);
        en_v = 4'b0000;
        cyc(1);
        mode2 = 1'b0;
        en_v  = 4'b1000;
        cyc(1);
        chk("t6_spin_load", remaining, 4);
        cyc(2 * TP);
        chk("t6_spin_mid", remaining, 2);
        chk("t6_spin_run", running, 1);
        rst = 1'b1;
        cyc(1);
        chk("t6_rst_rem", remaining, 0);
        chk("t6_rst_run", running, 0);
        chk("t6_rst_tmr", tmr, 0);
        chk("t6_rst_err", err, 0);
        rst  = 1'b0;
        en_v = 4'b0000;
        cyc(1);
        // Reset returns the latched mode to QUICK
        en_v = 4'b1000;
        cyc(1);
        chk("t6_quick_spin", remaining, 2);
        en_v = 4'b0000;
        cyc(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
